instr_fetch: RTL and testbench

Fetch stage directly downstream of the program counter register. It issues one instruction-memory read per PC value and holds the returned instruction for decode under a valid/ready handshake. It controls the PC's write port to stall the PC or redirect it. The PC register increments by 4 every cycle unless written, so this block decides when the PC advances.

---
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: one imem read per PC value, holds the returned instruction for decode,
// and steers the downstream-incrementing PC register through its write port.
module instr_fetch #(
    parameter int unsigned width_p       = 32,
    parameter int unsigned instr_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [width_p-1:0]       pc_i,
    output logic                     pc_wr_en_o,
    output logic [width_p-1:0]       pc_wr_dat_o,
    input  logic                     redirect_i,
    input  logic [width_p-1:0]       redirect_pc_i,
    output logic                     imem_req_valid_o,
    input  logic                     imem_req_ready_i,
    output logic [width_p-1:0]       imem_addr_o,
    input  logic                     imem_rsp_valid_i,
    input  logic [instr_width_p-1:0] imem_rsp_dat_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [instr_width_p-1:0] instr_o,
    output logic [width_p-1:0]       instr_pc_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e                   state_q;
    logic                     drop_q;
    logic [width_p-1:0]       pc_q;
    logic [instr_width_p-1:0] instr_q;
    logic                     req_fire;

    assign imem_addr_o = pc_i;
    assign instr_o     = instr_q;
    assign instr_pc_o  = pc_q;

    // Handshake outputs and PC write control; the PC only advances on an accepted request.
    always_comb begin
        imem_req_valid_o = 1'b0;
        instr_valid_o    = 1'b0;
        pc_wr_en_o       = 1'b1;
        pc_wr_dat_o      = pc_i;
        if (!rst_i) begin
            case (state_q)
                ST_REQ:  imem_req_valid_o = ~redirect_i;
                ST_FULL: instr_valid_o    = 1'b1;
                default: ;
            endcase
        end
        req_fire = imem_req_valid_o & imem_req_ready_i;
        if (rst_i) begin
            pc_wr_en_o = 1'b0;
        end else if (redirect_i) begin
            pc_wr_dat_o = redirect_pc_i;
        end else if (req_fire) begin
            pc_wr_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
            drop_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        pc_q    <= pc_i;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A redirect seen before or with the response makes that response stale.
                    if (imem_rsp_valid_i) begin
                        if (drop_q || redirect_i) begin
                            drop_q  <= 1'b0;
                            state_q <= ST_REQ;
                        end else begin
                            instr_q <= imem_rsp_dat_i;
                            state_q <= ST_FULL;
                        end
                    end else if (redirect_i) begin
                        drop_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (redirect_i || instr_ready_i) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC-register model and a variable-latency memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_wr_en;
    logic [31:0] pc_wr_dat;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int cnt      = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc),
        .pc_wr_en_o(pc_wr_en), .pc_wr_dat_o(pc_wr_dat),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_dat_i(rsp_dat),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc)
    );

    // PC register: +4 every cycle unless written.
    always @(posedge clk) begin
        if (rst) pc <= '0;
        else if (pc_wr_en) pc <= pc_wr_dat;
        else pc <= pc + 32'd4;
    end

    // Memory: response lat cycles after acceptance, data = 0x13 + addr.
    always @(posedge clk) begin
        if (cnt > 0) cnt <= cnt - 1;
        if (req_valid && req_ready) begin
            cnt       <= lat;
            pend_addr <= addr;
        end
    end
    assign rsp_valid = (cnt == 1);
    assign rsp_dat   = 32'h13 + pend_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller then drives inputs and checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b1; instr_ready = 1'b1;
        step(); step();
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_wr_en", 32'(pc_wr_en), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Zero-wait flow: request 0x0 and 0x4.
        check("req0_valid", 32'(req_valid), 32'd1);
        check("req0_addr", addr, 32'h0);
        check("req0_pc_wr_en", 32'(pc_wr_en), 32'd0);
        step(); #1;
        check("wait0_req_valid", 32'(req_valid), 32'd0);
        check("wait0_pc_hold", pc_wr_dat, 32'h4);
        check("wait0_pc_wr_en", 32'(pc_wr_en), 32'd1);
        step(); #1;
        check("full0_valid", 32'(instr_valid), 32'd1);
        check("full0_instr", instr, 32'h13);
        check("full0_pc", instr_pc, 32'h0);
        step(); #1;
        check("req1_addr", addr, 32'h4);
        check("req1_valid", 32'(req_valid), 32'd1);
        step(); step(); #1;
        check("full1_instr", instr, 32'h17);
        check("full1_pc", instr_pc, 32'h4);

        // Memory stall at 0x8.
        step(); req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", 32'(req_valid), 32'd1);
            check("stall_addr", addr, 32'h8);
            check("stall_wr_en", 32'(pc_wr_en), 32'd1);
            check("stall_wr_dat", pc_wr_dat, 32'h8);
            step();
        end
        req_ready = 1'b1;
        #1; check("stall_release_addr", addr, 32'h8);
        step(); step();

        // Decode backpressure in FULL.
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", instr, 32'h1B);
            check("bp_pc", instr_pc, 32'h8);
            check("bp_no_req", 32'(req_valid), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        #1; check("bp_accept_valid", 32'(instr_valid), 32'd1);
        step(); #1;
        check("after_bp_addr", addr, 32'hC);
        check("after_bp_req", 32'(req_valid), 32'd1);
        step(); step(); #1;
        check("full_c_instr", instr, 32'h1F);

        // Redirect in WAIT with a 3-cycle response.
        step(); lat = 3; #1;
        check("req10_addr", addr, 32'h10);
        step(); redirect = 1'b1; redirect_pc = 32'h100; #1;
        check("rdw_wr_en", 32'(pc_wr_en), 32'd1);
        check("rdw_wr_dat", pc_wr_dat, 32'h100);
        step(); redirect = 1'b0; lat = 1; #1;
        check("rdw_pc", pc, 32'h100);
        check("rdw_ivalid1", 32'(instr_valid), 32'd0);
        step(); #1;
        check("rdw_rsp_seen", 32'(rsp_valid), 32'd1);
        check("rdw_ivalid2", 32'(instr_valid), 32'd0);
        step(); #1;
        check("rdw_ivalid3", 32'(instr_valid), 32'd0);
        check("rdw_next_addr", addr, 32'h100);
        check("rdw_next_req", 32'(req_valid), 32'd1);
        step(); step(); #1;
        check("rdw_deliver_valid", 32'(instr_valid), 32'd1);
        check("rdw_deliver_pc", instr_pc, 32'h100);
        check("rdw_deliver_instr", instr, 32'h113);

        // Redirect coinciding with the response.
        step(); #1;
        check("req104_addr", addr, 32'h104);
        step(); redirect = 1'b1; redirect_pc = 32'h200; #1;
        check("rdr_rsp_seen", 32'(rsp_valid), 32'd1);
        step(); redirect = 1'b0; #1;
        check("rdr_ivalid", 32'(instr_valid), 32'd0);
        check("rdr_next_addr", addr, 32'h200);
        check("rdr_next_req", 32'(req_valid), 32'd1);

        // Redirect in FULL takes priority over instr_ready.
        step(); step(); #1;
        check("rdf_full", 32'(instr_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        check("rdf_wr_dat", pc_wr_dat, 32'h200);
        step(); redirect = 1'b0; #1;
        check("rdf_ivalid", 32'(instr_valid), 32'd0);
        check("rdf_next_addr", addr, 32'h200);

        // Reset while WAIT; stale response arrives the cycle after reset deasserts.
        lat = 4;
        step(); rst = 1'b1; #1;
        check("rstw_req_valid", 32'(req_valid), 32'd0);
        check("rstw_wr_en", 32'(pc_wr_en), 32'd0);
        step(); #1;
        check("rstw_ivalid", 32'(instr_valid), 32'd0);
        step(); rst = 1'b0; req_ready = 1'b0; lat = 1; #1;
        check("rstw_addr0", addr, 32'h0);
        check("rstw_req0_valid", 32'(req_valid), 32'd1);
        step(); #1;
        check("rstw_late_rsp", 32'(rsp_valid), 32'd1);
        check("rstw_late_ivalid", 32'(instr_valid), 32'd0);
        req_ready = 1'b1;
        step(); #1;
        check("rstw_ivalid_wait", 32'(instr_valid), 32'd0);
        check("rstw_wait_noreq", 32'(req_valid), 32'd0);
        step(); #1;
        check("rstw_deliver_valid", 32'(instr_valid), 32'd1);
        check("rstw_deliver_instr", instr, 32'h13);
        check("rstw_deliver_pc", instr_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
